// File: rtl/kbd_pkg.sv
// Shared constants and width helpers for the keyboard scan-code path.
package kbd_pkg;

  localparam int unsigned SCAN_W = 8;
  localparam logic [SCAN_W-1:0] NO_KEY = 8'h00;

  // Bits needed to hold an occupancy of 0..depth.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return unsigned'($clog2(depth + 1));
  endfunction

  // Bits needed for a counter running 0..n-1, never less than one.
  function automatic int unsigned ctr_w(input int unsigned n);
    return (n <= 2) ? 1 : unsigned'($clog2(n));
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous show-ahead FIFO; the head entry is presented on a register.
module sync_fifo
  import kbd_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = SCAN_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        out_data,
  output logic                     full,
  output logic                     empty,
  output logic [cnt_w(DEPTH)-1:0]  count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = cnt_w(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  rd_ptr_nxt;
  logic [CNT_W-1:0]  count_nxt;
  logic [DATA_W-1:0] head_nxt;
  logic              do_push;
  logic              do_pop;

  // Qualify push/pop and work out the occupancy and head after this edge.
  always_comb begin
    do_pop     = pop && !empty;
    do_push    = push && (!full || do_pop);
    rd_ptr_nxt = do_pop ? rd_ptr + PTR_W'(1) : rd_ptr;
    count_nxt  = count;
    if (do_push && !do_pop) begin
      count_nxt = count + CNT_W'(1);
    end else if (!do_push && do_pop) begin
      count_nxt = count - CNT_W'(1);
    end
    // A write into the slot that becomes the head bypasses the array.
    head_nxt = (do_push && (wr_ptr == rd_ptr_nxt)) ? push_data : mem[rd_ptr_nxt];
  end

  // Storage array; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, occupancy, flags and the registered head.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      out_data <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      rd_ptr   <= rd_ptr_nxt;
      count    <= count_nxt;
      empty    <= (count_nxt == '0);
      full     <= (count_nxt == CNT_W'(DEPTH));
      out_data <= head_nxt;
    end
  end

endmodule

// File: rtl/scan_code_fifo.sv
// Qualifies level-style scan codes with a stability filter and queues one
// event per key press for a valid/ready consumer.
module scan_code_fifo
  import kbd_pkg::*;
#(
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned DATA_W        = SCAN_W,
  parameter int unsigned STABLE_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        scan_code,
  input  logic                     scan_code_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [cnt_w(DEPTH)-1:0]  count,
  output logic                     overflow,
  input  logic                     clear_ovf
);

  localparam int unsigned CTR_W = ctr_w(STABLE_CYCLES);
  localparam logic [CTR_W-1:0] CTR_MAX = CTR_W'(STABLE_CYCLES - 1);

  logic [DATA_W-1:0] prev_code;
  logic [CTR_W-1:0]  stb_cnt;
  logic              armed;
  logic              hold_c;
  logic              push_c;
  logic              pop_c;
  logic              drop_c;
  logic              fifo_full;
  logic              fifo_empty;

  // A press is "held" when the same nonzero code is seen on consecutive edges.
  always_comb begin
    hold_c = scan_code_ready && (scan_code != DATA_W'(NO_KEY)) && (scan_code == prev_code);
    push_c = hold_c && (stb_cnt == CTR_MAX) && armed;
    pop_c  = out_valid && out_ready;
    drop_c = push_c && fifo_full && !pop_c;
  end

  // Stability counter; armed drops after one event so a held key never repeats.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_code <= '0;
      stb_cnt   <= '0;
      armed     <= 1'b1;
    end else begin
      prev_code <= scan_code;
      if (!hold_c) begin
        stb_cnt <= '0;
        armed   <= 1'b1;
      end else if (stb_cnt != CTR_MAX) begin
        stb_cnt <= stb_cnt + CTR_W'(1);
      end else if (armed) begin
        armed <= 1'b0;
      end
    end
  end

  // Sticky overflow; a drop on the same edge as a clear keeps it set.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (drop_c) begin
      overflow <= 1'b1;
    end else if (clear_ovf) begin
      overflow <= 1'b0;
    end
  end

  assign out_valid = !fifo_empty;

  sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push_c),
    .push_data (scan_code),
    .pop       (pop_c),
    .out_data  (out_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count)
  );

endmodule
